note_spawn_arbiter: RTL and testbench

NOTE_SPAWN_ARBITER -- requirements
Module: note_spawn_arbiter

---
 rtl/note_spawn_arbiter.sv | 125 ++++++++++++
 tb/tb_note_spawn_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/note_spawn_arbiter.sv
// note_spawn_arbiter: paces note spawns to frame ticks, picking one eligible lane per tick round-robin
// with per-lane cooldown, an on-screen cap, and an acknowledge handshake from the sprite modules.
module note_spawn_arbiter #(
  parameter int NUM_LANES       = 5,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_ACTIVE      = 3,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [4:0] req,
  input  logic [4:0] lane_busy,
  output logic [4:0] spawn,
  output logic [2:0] grant_lane,
  output logic [7:0] dropped_count,
  output logic [7:0] missed_ticks,
  output logic       timeout_err
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT_BUSY} state_t;
  state_t        state_q, state_d;
  logic [2:0]    sync_q;
  logic          tick_q;
  logic [4:0]    pend_q, pend_d, cool_ok_q, ok_now, elig, clr;
  logic [CW-1:0] cool_q [5];
  logic [2:0]    rr_q, win_q, win_d, grant_q, pick, idx, busy_cnt;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    drop_q, miss_q;
  logic          err_q, err_set, found, issue, drop;
  assign issue         = state_q == ISSUE && enable;
  assign clr           = issue ? 5'b00001 << win_q : 5'b0;
  assign spawn         = clr;
  assign grant_lane    = grant_q;
  assign dropped_count = drop_q;
  assign missed_ticks  = miss_q;
  assign timeout_err   = err_q;
  // A request landing on the lane being cleared re-arms it rather than counting as a drop.
  assign pend_d = enable ? ((pend_q & ~clr) | req) : 5'b0;
  assign drop   = |(req & pend_q & ~clr);
  assign elig   = pend_q & ~lane_busy & cool_ok_q & {5{busy_cnt < 3'(MAX_ACTIVE)}};
  always_comb begin
    busy_cnt = '0;
    ok_now = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      busy_cnt = busy_cnt + {2'b0, lane_busy[i]};
      ok_now[i] = cool_q[i] == '0;
    end
  end
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = 3'((int'(rr_q) + k) % NUM_LANES);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    tmr_d = tmr_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: state_d = (tick_q && enable) ? ARB : IDLE;
      ARB: begin
        state_d = found ? ISSUE : IDLE;
        win_d = found ? pick : win_q;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmr_d = '0;
      end
      WAIT_BUSY: begin
        err_set = !lane_busy[win_q] && tmr_q == TW'(ACK_TIMEOUT - 1);
        state_d = (lane_busy[win_q] || err_set) ? IDLE : WAIT_BUSY;
        tmr_d = tmr_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      err_set = 1'b0;
    end
  end
  // cool_ok_q snapshots cooldown-zero at the tick, before that tick's decrement lands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      tick_q <= 1'b0;
      state_q <= IDLE;
      win_q <= '0;
      tmr_q <= '0;
      pend_q <= '0;
      cool_ok_q <= '0;
      rr_q <= 3'd4;
      grant_q <= '0;
      drop_q <= '0;
      miss_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) cool_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
      state_q <= state_d;
      win_q <= win_d;
      tmr_q <= tmr_d;
      pend_q <= pend_d;
      err_q <= err_q | err_set;
      drop_q <= (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
      miss_q <= (tick_q && state_q != IDLE && miss_q != 8'hff) ? miss_q + 8'd1 : miss_q;
      cool_ok_q <= tick_q ? ok_now : cool_ok_q;
      rr_q <= issue ? win_q : rr_q;
      grant_q <= issue ? win_q : grant_q;
      for (int i = 0; i < NUM_LANES; i++)
        cool_q[i] <= clr[i] ? CW'(COOLDOWN_FRAMES) :
                     (tick_q && cool_q[i] != '0) ? cool_q[i] - CW'(1) : cool_q[i];
    end
  end
endmodule

// File: tb/tb_note_spawn_arbiter.sv
// tb_note_spawn_arbiter: directed scenarios for the note spawn arbiter with hand-computed expectations.
module tb_note_spawn_arbiter;
  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, enable = 1'b0;
  logic [4:0] req = '0, lane_busy = '0, busy_base = '0;
  logic [4:0] spawn;
  logic [2:0] grant_lane;
  logic [7:0] dropped_count, missed_ticks;
  logic       timeout_err;
  int checks = 0, errors = 0;
  always #10 Clk = ~Clk;
  note_spawn_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .req(req),
    .lane_busy(lane_busy), .spawn(spawn), .grant_lane(grant_lane),
    .dropped_count(dropped_count), .missed_ticks(missed_ticks), .timeout_err(timeout_err)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; enable = 1'b0; req = '0; busy_base = '0; lane_busy = '0; frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask
  task automatic pulse_req(input logic [4:0] r);
    @(negedge Clk) req = r;
    @(negedge Clk) req = '0;
  endtask
  // One frame_clk rise; records the first spawn and the negedge index it appeared on
  // (tick visible at index 3, so a 2-cycle spawn latency shows up at index 5).
  task automatic frame_pulse(input logic ack, input logic [4:0] rq, output logic [4:0] sp, output int at);
    logic [4:0] ackb;
    ackb = '0; sp = '0; at = -1;
    @(negedge Clk);
    frame_clk = 1'b1;
    lane_busy = busy_base;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 4) frame_clk = 1'b0;
      if (c == 5) req = rq;
      if (c == 6) req = '0;
      if (spawn !== 5'b0 && at < 0) begin
        sp = spawn;
        at = c;
        if (ack) ackb = spawn;
      end
      if (at > 0 && c == at + 2) ackb = '0;
      lane_busy = busy_base | ackb;
    end
  endtask
  task automatic test_reset();
    @(negedge Clk);
    checks++; if (spawn !== 5'b0) begin errors++; $display("FAIL reset_spawn: got %b expected 00000", spawn); end
    checks++; if (grant_lane !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_lane); end
    checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
    checks++; if (missed_ticks !== 8'd0) begin errors++; $display("FAIL reset_missed: got %0d expected 0", missed_ticks); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
  endtask
  task automatic test_basic_grant();
    logic [4:0] sp; int at;
    do_reset(); enable = 1'b1;
    pulse_req(5'b00001);
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b00001) begin errors++; $display("FAIL basic_spawn: got %b expected 00001", sp); end
    checks++; if (at !== 5) begin errors++; $display("FAIL basic_latency: got index %0d expected 5", at); end
    checks++; if (grant_lane !== 3'd0) begin errors++; $display("FAIL basic_grant_lane: got %0d expected 0", grant_lane); end
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b0) begin errors++; $display("FAIL basic_idle_nospawn: got %b expected 00000", sp); end
    checks++; if (missed_ticks !== 8'd0) begin errors++; $display("FAIL basic_back_to_idle: missed got %0d expected 0", missed_ticks); end
  endtask
  task automatic test_round_robin();
    logic [4:0] sp; int at;
    logic [4:0] exp_sp [3] = '{5'b00001, 5'b00010, 5'b10000};
    logic [2:0] exp_ln [3] = '{3'd0, 3'd1, 3'd4};
    do_reset(); enable = 1'b1;
    pulse_req(5'b10011);
    for (int k = 0; k < 3; k++) begin
      frame_pulse(1'b1, 5'b0, sp, at);
      checks++; if (sp !== exp_sp[k]) begin errors++; $display("FAIL rr_spawn[%0d]: got %b expected %b", k, sp, exp_sp[k]); end
      checks++; if (grant_lane !== exp_ln[k]) begin errors++; $display("FAIL rr_lane[%0d]: got %0d expected %0d", k, grant_lane, exp_ln[k]); end
    end
  endtask
  task automatic test_cooldown();
    logic [4:0] sp; int at; int n;
    do_reset(); enable = 1'b1;
    pulse_req(5'b00100);
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b00100) begin errors++; $display("FAIL cool_first: got %b expected 00100", sp); end
    pulse_req(5'b00100);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      frame_pulse(1'b1, 5'b0, sp, at);
      if (sp !== 5'b0) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL cool_blocked: got %0d grants expected 0", n); end
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b00100) begin errors++; $display("FAIL cool_ninth: got %b expected 00100", sp); end
    do_reset(); enable = 1'b1; busy_base = 5'b01011; lane_busy = busy_base;
    pulse_req(5'b00100);
    frame_pulse(1'b0, 5'b0, sp, at);
    checks++; if (sp !== 5'b0) begin errors++; $display("FAIL max_active_block: got %b expected 00000", sp); end
    busy_base = 5'b00011;
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b00100) begin errors++; $display("FAIL max_active_release: got %b expected 00100", sp); end
  endtask
  task automatic test_drop();
    logic [4:0] sp; int at;
    do_reset(); enable = 1'b1; busy_base = 5'b01000; lane_busy = busy_base;
    repeat (3) pulse_req(5'b01000);
    checks++; if (dropped_count !== 8'd2) begin errors++; $display("FAIL drop_count: got %0d expected 2", dropped_count); end
    repeat (297) pulse_req(5'b01000);
    checks++; if (dropped_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", dropped_count); end
    do_reset(); enable = 1'b1;
    pulse_req(5'b00001);
    frame_pulse(1'b1, 5'b00001, sp, at);
    checks++; if (sp !== 5'b00001) begin errors++; $display("FAIL issue_req_spawn: got %b expected 00001", sp); end
    checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL issue_req_nodrop: got %0d expected 0", dropped_count); end
    pulse_req(5'b00001);
    checks++; if (dropped_count !== 8'd1) begin errors++; $display("FAIL issue_req_pending: got %0d expected 1", dropped_count); end
  endtask
  task automatic test_timeout_missed();
    logic [4:0] sp; int at;
    do_reset(); enable = 1'b1;
    pulse_req(5'b00001);
    frame_pulse(1'b0, 5'b0, sp, at);
    checks++; if (sp !== 5'b00001) begin errors++; $display("FAIL to_spawn: got %b expected 00001", sp); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout_err); end
    frame_pulse(1'b0, 5'b0, sp, at);
    checks++; if (sp !== 5'b0) begin errors++; $display("FAIL missed_nospawn: got %b expected 00000", sp); end
    checks++; if (missed_ticks !== 8'd1) begin errors++; $display("FAIL missed_count: got %0d expected 1", missed_ticks); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_cycle15: got %b expected 0", timeout_err); end
    @(negedge Clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_cycle16: got %b expected 1", timeout_err); end
    repeat (20) @(negedge Clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
  endtask
  task automatic test_enable_off();
    logic [4:0] sp; int at;
    do_reset(); enable = 1'b1;
    pulse_req(5'b00001);
    @(negedge Clk) enable = 1'b0;
    @(negedge Clk) enable = 1'b1;
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b0) begin errors++; $display("FAIL en_clear_pending: got %b expected 00000", sp); end
    enable = 1'b0;
    pulse_req(5'b00010);
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b0) begin errors++; $display("FAIL en_off_nospawn: got %b expected 00000", sp); end
    checks++; if (missed_ticks !== 8'd0) begin errors++; $display("FAIL en_off_missed: got %0d expected 0", missed_ticks); end
  endtask
  task automatic test_reset_mid_issue();
    logic [4:0] sp; int at;
    do_reset(); enable = 1'b1;
    pulse_req(5'b00100);
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (grant_lane !== 3'd2) begin errors++; $display("FAIL rst_pre_grant: got %0d expected 2", grant_lane); end
    pulse_req(5'b00010);
    pulse_req(5'b00010);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    checks++; if (spawn !== 5'b00010) begin errors++; $display("FAIL rst_pre_spawn: got %b expected 00010", spawn); end
    Reset = 1'b1;
    #1;
    checks++; if (spawn !== 5'b0) begin errors++; $display("FAIL rst_spawn: got %b expected 00000", spawn); end
    checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL rst_dropped: got %0d expected 0", dropped_count); end
    checks++; if (grant_lane !== 3'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_lane); end
    checks++; if (missed_ticks !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got missed %0d err %b expected 0 0", missed_ticks, timeout_err); end
    @(negedge Clk) Reset = 1'b0;
    pulse_req(5'b00011);
    frame_pulse(1'b1, 5'b0, sp, at);
    checks++; if (sp !== 5'b00001) begin errors++; $display("FAIL rst_first_grant: got %b expected 00001", sp); end
  endtask
  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_cooldown();
    test_drop();
    test_timeout_missed();
    test_enable_off();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
